// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage for the unpipelined MIPS core. Holds the fetch PC
//   and issues one request at a time to a variable-latency instruction memory.
//   Each fetched word is presented through a valid/ready handshake. On
//   consumption, the next PC is either PC+4 or the execute-stage target.
//   A flush restarts fetch at an arbitrary address. If a request is still
//   outstanding at that point, its response is dropped.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_pcsrc, i_nextPC       next-PC select / target from execute
//   i_flush, i_flush_pc     restart fetch at i_flush_pc (highest priority)
//   o_imem_req/o_imem_addr  memory request, address held until ack
//   i_imem_ack/i_imem_data  memory response
//   o_valid, i_ready        output handshake
//   o_pc, o_instr           fetched instruction and its address
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pcsrc,
   input  logic [31:0] i_nextPC,
   input  logic        i_flush,
   input  logic [31:0] i_flush_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,  // request to fetch_pc outstanding
      DROP  = 2'd1,  // abandoned request to req_addr still in flight
      OUT   = 2'd2   // instruction held on o_pc/o_instr
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, fetch_pc_nxt;
   logic [31:0] req_addr, req_addr_nxt;
   logic        capture;

   // Word-align incoming addresses. Masking keeps every input bit in use.
   logic [31:0] branch_pc, flush_pc, seq_pc;
   assign branch_pc = i_nextPC   & ~32'h3;
   assign flush_pc  = i_flush_pc & ~32'h3;
   assign seq_pc    = o_pc + 32'd4;   // wraps to 0 past 0xFFFF_FFFC

   // ---------------- state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= FETCH;
      else       state <= state_nxt;
   end

   // ---------------- next state / datapath control ----------------
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      req_addr_nxt = req_addr;
      capture      = 1'b0;
      case (state)
         FETCH: begin
            if (i_flush) begin
               fetch_pc_nxt = flush_pc;
               if (!i_imem_ack) begin
                  // The bus still owes us a response for the old address.
                  // Keep that address on the bus until the response arrives.
                  req_addr_nxt = fetch_pc;
                  state_nxt    = DROP;
               end
            end else if (i_imem_ack) begin
               capture   = 1'b1;
               state_nxt = OUT;
            end
         end
         DROP: begin
            if (i_flush) fetch_pc_nxt = flush_pc;
            if (i_imem_ack) state_nxt = FETCH;
         end
         OUT: begin
            if (i_flush) begin
               // A same-cycle i_ready consumes the word, but the flush target
               // wins over any branch.
               fetch_pc_nxt = flush_pc;
               state_nxt    = FETCH;
            end else if (i_ready) begin
               fetch_pc_nxt = i_pcsrc ? branch_pc : seq_pc;
               state_nxt    = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         o_pc     <= RESET_PC;
         o_instr  <= 32'h0;
      end else begin
         fetch_pc <= fetch_pc_nxt;
         req_addr <= req_addr_nxt;
         if (capture) begin
            o_pc    <= fetch_pc;
            o_instr <= i_imem_data;
         end
      end
   end

   // ---------------- outputs ----------------
   // These outputs are state-derived only, so there is no path from
   // i_imem_ack. The request is held low while reset is asserted.
   assign o_valid     = (state == OUT);
   assign o_imem_req  = !i_rst && (state != OUT);
   assign o_imem_addr = (state == DROP) ? req_addr : fetch_pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0040;

   logic        i_clk = 1'b0, i_rst = 1'b1, i_pcsrc = 1'b0, i_flush = 1'b0;
   logic        i_imem_ack = 1'b0, i_ready = 1'b0;
   logic [31:0] i_nextPC = '0, i_flush_pc = '0, i_imem_data = '0;
   logic        o_imem_req, o_valid;
   logic [31:0] o_imem_addr, o_pc, o_instr;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pcsrc(i_pcsrc), .i_nextPC(i_nextPC),
      .i_flush(i_flush), .i_flush_pc(i_flush_pc),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
      .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_instr(o_instr));

   always #5 i_clk = ~i_clk;

   int checks = 0, errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_q(string name, logic [31:0] got[$], logic [31:0] exp[$]);
      check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         check(name, (i < got.size()) ? got[i] : 32'hxxxx_xxxx, exp[i]);
   endtask

   function automatic logic [31:0] memfn(logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   // ---------------- reference model ----------------
   // The model tracks whether an instruction is held, which address the bus
   // is working on, and whether that pending response is to be discarded.
   bit          started = 0;
   logic        m_valid = 0, m_discard = 0;
   logic [31:0] m_pc = RST_PC, m_instr = 0, m_next = RST_PC, m_bus = RST_PC;

   always @(posedge i_clk) begin
      if (i_rst) begin
         started = 1; m_valid = 0; m_discard = 0;
         m_pc = RST_PC; m_instr = 0; m_next = RST_PC; m_bus = RST_PC;
      end else if (started) begin
         if (m_valid) begin
            if (i_flush) begin
               m_valid = 0; m_next = i_flush_pc & ~32'h3; m_bus = m_next;
            end else if (i_ready) begin
               m_valid = 0;
               m_next  = i_pcsrc ? (i_nextPC & ~32'h3) : m_pc + 32'd4;
               m_bus   = m_next;
            end
         end else begin
            if (i_flush) begin
               m_next = i_flush_pc & ~32'h3;
               if (i_imem_ack) begin m_discard = 0; m_bus = m_next; end
               else m_discard = 1;
            end else if (i_imem_ack) begin
               if (m_discard) begin m_discard = 0; m_bus = m_next; end
               else begin m_valid = 1; m_pc = m_bus; m_instr = i_imem_data; end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge i_clk) begin
      #1;
      if (started) begin
         check("valid", 32'(o_valid), 32'(m_valid));
         check("req", 32'(o_imem_req), 32'(!i_rst && !m_valid));
         check("pc", o_pc, m_pc);
         check("instr", o_instr, m_instr);
         if (!i_rst && !m_valid) check("addr", o_imem_addr, m_bus);
      end
   end

   // ---------------- transaction logs ----------------
   logic [31:0] acc_q[$], hs_pc[$], hs_in[$];
   always @(posedge i_clk) begin
      if (!i_rst && o_imem_req && i_imem_ack) acc_q.push_back(o_imem_addr);
      if (!i_rst && o_valid && i_ready) begin
         hs_pc.push_back(o_pc); hs_in.push_back(o_instr);
      end
   end

   // ---------------- memory + driver ----------------
   int mode = 0;   // 0 zero-wait, 1 three wait cycles, 2 random 0..3
   bit busy = 0;
   int wcnt = 0;

   task automatic cyc();
      if (i_rst || m_valid) begin
         i_imem_ack = 0;
         if (i_rst) busy = 0;
      end else begin
         if (!busy) begin
            busy = 1;
            wcnt = (mode == 0) ? 0 : (mode == 1) ? 3 : int'($urandom_range(0, 3));
         end
         if (wcnt == 0) begin
            i_imem_ack = 1; i_imem_data = memfn(o_imem_addr); busy = 0;
         end else begin
            i_imem_ack = 0; i_imem_data = $urandom; wcnt--;
         end
      end
      @(posedge i_clk); @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_rst = 1; i_flush = 0; i_ready = 0; i_pcsrc = 0;
      cyc(); cyc();
      i_rst = 0;
      acc_q.delete(); hs_pc.delete(); hs_in.delete();
   endtask

   initial begin
      int n;
      @(negedge i_clk);
      // Sequential fetch with zero-wait memory
      do_reset(); mode = 0; i_ready = 1;
      repeat (6) cyc();
      chk_q("seq_addr", acc_q, '{32'h40, 32'h44, 32'h48});

      // Branch taken on the handshake of 0x44
      do_reset(); mode = 0; i_ready = 1; i_nextPC = 32'h0000_0103;
      repeat (8) begin i_pcsrc = o_valid && (o_pc == 32'h44); cyc(); end
      i_pcsrc = 0;
      chk_q("br_addr", acc_q, '{32'h40, 32'h44, 32'h100, 32'h104});

      // Three wait states: o_valid appears after the fourth request cycle
      do_reset(); mode = 1; i_ready = 1; n = 0;
      while (!o_valid && n < 20) begin cyc(); n++; end
      check("wait_lat", 32'(n), 32'd4);
      repeat (6) cyc();

      // Backpressure with i_pcsrc toggling
      do_reset(); mode = 0; i_ready = 0;
      cyc();
      for (int i = 0; i < 5; i++) begin i_pcsrc = i[0]; i_nextPC = 32'h300; cyc(); end
      i_ready = 1; i_pcsrc = 0; cyc();
      i_ready = 0; cyc(); cyc();
      chk_q("bp_addr", acc_q, '{32'h40, 32'h44});
      chk_q("bp_hs", hs_pc, '{32'h40});

      // Flush while the request to 0x48 is still waiting
      do_reset(); mode = 0; i_ready = 1;
      repeat (4) cyc();
      mode = 1; cyc();
      i_flush = 1; i_flush_pc = 32'h0000_0201; cyc();
      i_flush = 0; cyc(); cyc();
      mode = 0; cyc(); cyc();
      chk_q("fl_addr", acc_q, '{32'h40, 32'h44, 32'h48, 32'h200});
      chk_q("fl_hs", hs_pc, '{32'h40, 32'h44, 32'h200});
      chk_q("fl_instr", hs_in, '{memfn(32'h40), memfn(32'h44), memfn(32'h200)});

      // PC wrap-around, then reset while holding an instruction
      do_reset(); mode = 0; i_ready = 0;
      cyc();
      i_flush = 1; i_flush_pc = 32'hFFFF_FFFE; cyc();
      i_flush = 0; i_ready = 1; acc_q.delete();
      repeat (3) cyc();
      chk_q("wrap_addr", acc_q, '{32'hFFFF_FFFC, 32'h0});
      check("wrap_pc", o_pc, 32'h0);
      i_ready = 0; i_rst = 1; cyc();
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_pc", o_pc, RST_PC);
      check("rst_req", 32'(o_imem_req), 32'd0);
      i_rst = 0;

      // Randomized traffic
      mode = 2;
      for (int i = 0; i < 3000; i++) begin
         i_rst      = ($urandom_range(0, 199) == 0);
         i_ready    = ($urandom_range(0, 2) != 0);
         i_pcsrc    = $urandom_range(0, 1);
         i_nextPC   = $urandom;
         i_flush    = ($urandom_range(0, 15) == 0);
         i_flush_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7))
                                                  : $urandom;
         cyc();
      end
      i_rst = 0; i_flush = 0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the unpipelined MIPS core: the consumer of the execute stage's `o_nextPC`/`o_pcsrc` outputs and the producer of the PC and instruction that feed decode/execute. Holds the architectural PC, issues one-at-a-time requests to a variable-latency instruction memory, and presents each fetched instruction through a valid/ready handshake. On each consumed instruction it selects the next PC: the sequential PC+4, or the branch/jump target computed by execute. A separate flush input restarts fetch at an arbitrary address.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0
- `i_clk` in 1, clock; all state updates on rising edge
- `i_rst` in 1, synchronous active-high reset
- `i_pcsrc` in 1, from execute: 1 = take `i_nextPC`, 0 = PC+4; sampled only on output handshake
- `i_nextPC` in 32, from execute: branch/jump target; bits [1:0] ignored and forced to 00
- `i_flush` in 1, restart fetch; highest priority
- `i_flush_pc` in 32, restart address; bits [1:0] forced to 00
- `o_imem_req` out 1, instruction memory request
- `o_imem_addr` out 32, request address; stable while `o_imem_req` = 1
- `i_imem_ack` in 1, memory response valid; may be asserted in the same cycle as `o_imem_req`
- `i_imem_data` in 32, instruction word; valid when `i_imem_ack` = 1
- `o_valid` out 1, `o_pc`/`o_instr` hold a fetched instruction
- `i_ready` in 1, downstream accepts the instruction this cycle
- `o_pc` out 32, address of `o_instr`; drives execute `i_pc`
- `o_instr` out 32, fetched instruction word

## Operation
- State register: FETCH, DROP, OUT. A 32-bit `fetch_pc` register supplies `o_imem_addr`.
- Reset: state = FETCH, `fetch_pc` = `RESET_PC`, `o_pc` = `RESET_PC`, `o_instr` = 0, `o_valid` = 0. `o_imem_req` is 0 during reset and 1 from the first cycle after reset.
- FETCH: `o_imem_req` = 1, `o_imem_addr` = `fetch_pc`.
  - Ack: capture `o_instr` = data and `o_pc` = `fetch_pc`, then go to OUT.
  - No ack: stay in FETCH.
- OUT: `o_valid` = 1, `o_imem_req` = 0, outputs held stable.
  - On `i_ready`: `fetch_pc` = `i_pcsrc` ? {`i_nextPC`[31:2],2'b00} : `o_pc` + 4 (mod 2^32, wraps to 0). Then go to FETCH.
  - Without `i_ready`: stay in OUT; `i_pcsrc`/`i_nextPC` are ignored.
- DROP: `o_imem_req` = 1 with the old address held until ack. The response is discarded, then go to FETCH at `fetch_pc`. Exactly one outstanding request exists at any time.
- Flush, which overrides all of the above:
  - FETCH with ack in the same cycle: discard the data, `fetch_pc` = `i_flush_pc`, stay in FETCH.
  - FETCH without ack: `fetch_pc` = `i_flush_pc`, go to DROP. The bus address stays on the old value; a separate `req_addr` register holds it.
  - DROP: update `fetch_pc`, stay in DROP. With ack the same cycle, go to FETCH at the new `fetch_pc`.
  - OUT: `o_valid` = 0 next cycle, `fetch_pc` = `i_flush_pc`, go to FETCH. If `i_ready` is high the same cycle, the instruction counts as consumed but `i_pcsrc` is ignored.
- Reset asserted mid-operation discards any outstanding request and its late ack. The memory side must tolerate this.

## Timing
- Ack to `o_valid` is 1 cycle (registered outputs); `o_instr`/`o_pc` are never combinational from `i_imem_data`.
- Handshake to `o_imem_req` is 1 cycle. With zero-wait memory (ack in the request cycle), throughput is 1 instruction per 2 cycles.
- Each memory wait cycle adds exactly 1 cycle. A DROP adds the remaining latency of the abandoned request plus one new fetch.
- `o_valid` never drops without a handshake, except on flush or reset.
- `o_imem_addr` and `o_imem_req` are registered or state-derived only, with no combinational path from `i_imem_ack`.

## Test plan
- Reset with `RESET_PC` = 32'h0000_0040 and zero-wait memory, `i_ready` = 1, `i_pcsrc` = 0 → requests to 0x40, 0x44, 0x48. `o_pc` follows the same sequence; `o_valid` is high every other cycle.
- Branch: on the handshake of `o_pc` = 0x44 drive `i_pcsrc` = 1, `i_nextPC` = 0x0000_0103 → next request address 0x0000_0100, then 0x104.
- Wait states: ack 3 cycles after req → `o_imem_addr` stable for 4 cycles; `o_valid` rises on the cycle after ack.
- Backpressure: `i_ready` = 0 for 5 cycles with `i_pcsrc` toggling → `o_pc`/`o_instr` held stable, no new request. On release with `i_pcsrc` = 0 → next address is `o_pc` + 4.
- Flush mid-request: `i_flush` with `i_flush_pc` = 0x200 while a request to 0x48 is pending → address stays 0x48 until ack; that data never appears on `o_instr`; the next request goes to 0x200.
- Wrap-around and reset: `o_pc` = 0xFFFF_FFFC consumed with `i_pcsrc` = 0 → next address 0x0. Asserting `i_rst` in OUT → next cycle `o_valid` = 0, `o_pc` = `RESET_PC`.
